// File: rtl/dma_copy_engine_if.sv
// Single-cycle memory-mapped bus between an initiator and a slave.
// The slave must return RD combinationally for the current A.
interface dma_copy_engine_if;
  logic [31:0] A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output A, output WE, output WD, input RD);
  modport slave  (input A, input WE, input WD, output RD);
endinterface

// File: rtl/dma_copy_engine.sv
// Word-copy DMA initiator: a READ/WRITE pair per word over a single-cycle bus.
// Source and destination may each be held fixed, which allows a peripheral
// register to be streamed to RAM or RAM to be streamed to a peripheral.
module dma_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      srcAddr,
  input  logic [31:0]      dstAddr,
  input  logic [LEN_W-1:0] len,
  input  logic             srcFixed,
  input  logic             dstFixed,
  input  logic             abort,
  input  logic             irqClear,
  output logic             busy,
  output logic             done,
  output logic             dmaIRQ,
  output logic [LEN_W-1:0] wordsLeft,
  dma_copy_engine_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [29:0]      r_src;
  logic [29:0]      r_dst;
  logic [LEN_W-1:0] r_count;
  logic             r_src_fixed;
  logic             r_dst_fixed;
  logic [31:0]      r_data;
  logic             r_irq;
  logic             w_enter_done;

  // Byte-offset bits of the programmed addresses carry no meaning.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{srcAddr[1:0], dstAddr[1:0]};

  assign wordsLeft    = r_count;
  assign dmaIRQ       = r_irq;
  assign w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);

  // State register; reset is asynchronous so the bus is released at once.
  always_ff @(posedge CLK or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode: abort only matters while the bus is in use.
  always_comb begin
    // NOTE: default first so no path through the case leaves it unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = (len == '0) ? S_DONE : S_READ;
      S_READ:  w_next_state = abort ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (abort)                         w_next_state = S_IDLE;
        else if (r_count == LEN_W'(1))     w_next_state = S_DONE;
        else                               w_next_state = S_READ;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bus and status outputs; abort gates WE in the same cycle to avoid a partial write.
  always_comb begin
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    bus.A  = '0;
    bus.WE = 1'b0;
    bus.WD = '0;
    case (r_state)
      S_READ:  bus.A = {r_src, 2'b00};
      S_WRITE: begin
        bus.A  = {r_dst, 2'b00};
        bus.WE = ~abort;
        bus.WD = r_data;
      end
      default: ;
    endcase
  end

  // Transfer datapath: parameter latch, read capture, word count and address stepping.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_count     <= '0;
      r_src_fixed <= 1'b0;
      r_dst_fixed <= 1'b0;
      r_data      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src       <= srcAddr[31:2];
            r_dst       <= dstAddr[31:2];
            r_count     <= len;
            r_src_fixed <= srcFixed;
            r_dst_fixed <= dstFixed;
          end
        end
        S_READ: begin
          r_data <= bus.RD;
          if (abort) r_count <= '0;
        end
        S_WRITE: begin
          if (abort) begin
            r_count <= '0;
          end else begin
            r_count <= r_count - LEN_W'(1);
            // 30-bit word addresses wrap modulo 2^30 on their own.
            if (!r_src_fixed) r_src <= r_src + 30'd1;
            if (!r_dst_fixed) r_dst <= r_dst + 30'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky completion interrupt; a completion in the same cycle as a clear wins.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)             r_irq <= 1'b0;
    else if (w_enter_done) r_irq <= 1'b1;
    else if (irqClear)     r_irq <= 1'b0;
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: a bus memory with a free-running
// timer register, and a sequential word-copy reference model per transfer.
module tb_dma_copy_engine;
  localparam int          LEN_W      = 16;
  localparam logic [31:0] TIMER_ADDR = 32'h2000_0000;

  logic             CLK = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      srcAddr;
  logic [31:0]      dstAddr;
  logic [LEN_W-1:0] len;
  logic             srcFixed;
  logic             dstFixed;
  logic             abort;
  logic             irqClear;
  logic             busy;
  logic             done;
  logic             dmaIRQ;
  logic [LEN_W-1:0] wordsLeft;

  int n_checks = 0;
  int n_fail   = 0;

  dma_copy_engine_if bus ();

  dma_copy_engine #(.LEN_W(LEN_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .len       (len),
    .srcFixed  (srcFixed),
    .dstFixed  (dstFixed),
    .abort     (abort),
    .irqClear  (irqClear),
    .busy      (busy),
    .done      (done),
    .dmaIRQ    (dmaIRQ),
    .wordsLeft (wordsLeft),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  // Bus slave: 4096-word RAM aliased on A[13:2] plus a timer register.
  logic [31:0] mem       [0:4095];
  logic [31:0] model_mem [0:4095];
  logic [31:0] timer = 32'h0000_0100;
  logic        mem_fill = 1'b0;
  logic        poke_en  = 1'b0;
  logic [31:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  assign bus.RD = (bus.A == TIMER_ADDR) ? timer : mem[bus.A[13:2]];

  always @(posedge CLK) timer <= timer + 32'd1;

  always @(posedge CLK) begin
    if (mem_fill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= $urandom;
    end else if (poke_en) begin
      mem[poke_addr[13:2]] <= poke_data;
    end else if (bus.WE) begin
      mem[bus.A[13:2]] <= bus.WD;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    poke_addr = addr;
    poke_data = data;
    poke_en   = 1'b1;
    step();
    poke_en   = 1'b0;
  endtask

  task automatic clear_irq();
    irqClear = 1'b1;
    step();
    irqClear = 1'b0;
    check("irq_cleared", 32'(dmaIRQ), 32'd0);
  endtask

  // One transfer from cycle 0 onward. abort_k/glitch_k/clr_k name the cycle
  // in which abort, a stray start, or irqClear is driven (0 = never).
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int n,
                          input bit sf, input bit df,
                          input int abort_k, input int glitch_k, input int clr_k);
    logic [29:0] sw;
    logic [29:0] dw;
    logic [31:0] t0;
    logic [31:0] data;
    int          last;
    int          diffs;
    model_mem = mem;
    srcAddr  = src;
    dstAddr  = dst;
    len      = LEN_W'(n);
    srcFixed = sf;
    dstFixed = df;
    start    = 1'b1;
    t0       = timer;
    sw       = src[31:2];
    dw       = dst[31:2];
    data     = '0;
    last     = (abort_k > 0) ? abort_k : 2 * n;
    for (int k = 1; k <= last; k++) begin
      step();
      start    = (k == glitch_k);
      irqClear = (k == clr_k);
      if (k == glitch_k) begin
        srcAddr  = $urandom;
        dstAddr  = $urandom;
        len      = LEN_W'($urandom_range(1, 9));
        srcFixed = ~sf;
        dstFixed = ~df;
      end
      if (k == abort_k) begin
        abort = 1'b1;
        #1;
      end
      check("busy", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      check("words_left", 32'(wordsLeft), 32'(n - (k - 1) / 2));
      if (k % 2 == 1) begin
        check("read_addr", bus.A, {sw, 2'b00});
        check("read_we", 32'(bus.WE), 32'd0);
        data = ({sw, 2'b00} == TIMER_ADDR) ? t0 + 32'(k) : model_mem[sw[11:0]];
      end else begin
        check("write_addr", bus.A, {dw, 2'b00});
        check("write_we", 32'(bus.WE), (k == abort_k) ? 32'd0 : 32'd1);
        if (k != abort_k) begin
          check("write_data", bus.WD, data);
          model_mem[dw[11:0]] = data;
          if (!sf) sw = sw + 30'd1;
          if (!df) dw = dw + 30'd1;
        end
      end
    end
    step();
    start    = 1'b0;
    abort    = 1'b0;
    irqClear = 1'b0;
    if (abort_k > 0) begin
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_irq", 32'(dmaIRQ), 32'd0);
      check("abort_left", 32'(wordsLeft), 32'd0);
      check("abort_we", 32'(bus.WE), 32'd0);
    end else begin
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_irq", 32'(dmaIRQ), 32'd1);
      check("done_we", 32'(bus.WE), 32'd0);
      check("done_left", 32'(wordsLeft), 32'd0);
      step();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_addr", bus.A, 32'd0);
      check("idle_we", 32'(bus.WE), 32'd0);
      check("idle_left", 32'(wordsLeft), 32'd0);
      check("idle_irq", 32'(dmaIRQ), 32'd1);
    end
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== model_mem[i]) diffs++;
    check("mem_image", 32'(diffs), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    srcAddr  = '0;
    dstAddr  = '0;
    len      = '0;
    srcFixed = 1'b0;
    dstFixed = 1'b0;
    abort    = 1'b0;
    irqClear = 1'b0;
    mem_fill = 1'b1;
    step();
    mem_fill = 1'b0;
    step();

    // Reset values while reset is held.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_irq", 32'(dmaIRQ), 32'd0);
    check("rst_left", 32'(wordsLeft), 32'd0);
    check("rst_addr", bus.A, 32'd0);
    check("rst_we", 32'(bus.WE), 32'd0);
    check("rst_wd", bus.WD, 32'd0);
    reset = 1'b0;
    step();

    // Three-word copy with known data.
    poke(32'h1000, 32'hA);
    poke(32'h1004, 32'hB);
    poke(32'h1008, 32'hC);
    run_xfer(32'h1000, 32'h2000, 3, 1'b0, 1'b0, 0, 0, 0);
    check("copy_w0", mem[32'h2000 >> 2], 32'hA);
    check("copy_w1", mem[32'h2004 >> 2], 32'hB);
    check("copy_w2", mem[32'h2008 >> 2], 32'hC);

    // Zero-length transfer: straight to DONE, no bus activity.
    clear_irq();
    run_xfer(32'h1000, 32'h2400, 0, 1'b0, 1'b0, 0, 0, 0);

    // Stream the timer register to RAM with a fixed source.
    run_xfer(TIMER_ADDR, 32'h3000, 4, 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      check("timer_delta", mem[(32'h3000 >> 2) + i + 1] - mem[(32'h3000 >> 2) + i], 32'd2);

    // Abort in the second WRITE of a five-word transfer.
    clear_irq();
    run_xfer(32'h1100, 32'h2100, 5, 1'b0, 1'b0, 4, 0, 0);

    // Abort during a READ.
    run_xfer(32'h1200, 32'h2200, 3, 1'b0, 1'b0, 3, 0, 0);

    // Stray start mid-transfer, and irqClear in the cycle that enters DONE.
    clear_irq();
    run_xfer(32'h1300, 32'h2300, 4, 1'b0, 1'b0, 0, 3, 8);

    // Address wrap at the top of the space, overlapping source and destination.
    run_xfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b0, 1'b0, 0, 0, 0);

    // Fixed destination collects only the last word.
    run_xfer(32'h0800, 32'h0C00, 3, 1'b0, 1'b1, 0, 0, 0);

    // Randomized transfers inside the RAM window.
    for (int r = 0; r < 6; r++) begin
      run_xfer(32'($urandom_range(0, 4095)) << 2, 32'($urandom_range(0, 4095)) << 2,
               int'($urandom_range(1, 6)), 1'($urandom), 1'($urandom), 0, 0, 0);
    end

    // irqClear in IDLE drops the interrupt.
    clear_irq();

    // Asynchronous reset in the middle of a WRITE cycle.
    srcAddr = 32'h1000;
    dstAddr = 32'h2800;
    len     = LEN_W'(3);
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre_reset_we", 32'(bus.WE), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_addr", bus.A, 32'd0);
    check("async_we", 32'(bus.WE), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_left", 32'(wordsLeft), 32'd0);
    #1;
    reset = 1'b0;
    step();
    check("post_reset_busy", 32'(busy), 32'd0);
    run_xfer(32'h1004, 32'h2C00, 1, 1'b0, 1'b0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-copy DMA initiator driving the SoC's single-cycle memory-mapped bus (A/WE/WD/RD) from the master side. Copies a programmed number of 32-bit words from a source to a destination address, optionally holding either address fixed, so a peripheral register (e.g. the system timer's mtime word) can be streamed to RAM or RAM to a peripheral. It sits beside the core as a second bus initiator; an external arbiter grants it the bus while `busy` is high. It raises a sticky completion interrupt.

## Interface
- LEN_W, 16, width of the word-count input and internal counter
- CLK  input  1  system clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a transfer; sampled only in IDLE
- srcAddr  input  32  source byte address; bits [1:0] ignored
- dstAddr  input  32  destination byte address; bits [1:0] ignored
- len  input  LEN_W  number of words to copy
- srcFixed  input  1  1: source address not incremented
- dstFixed  input  1  1: destination address not incremented
- abort  input  1  cancel an in-progress transfer
- irqClear  input  1  clear `dmaIRQ`
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- dmaIRQ  output  1  sticky completion interrupt
- wordsLeft  output  LEN_W  words still to be written
- A  output  32  bus address, bits [1:0] always 0
- WE  output  1  bus write enable
- WD  output  32  bus write data
- RD  input  32  bus read data, combinationally valid for current A

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: A=0, WE=0, WD=0, busy=0. On start=1: latch srcAddr[31:2], dstAddr[31:2], len, srcFixed, dstFixed; if len==0 go DONE, else go READ.
- READ: A={srcReg,2'b00}, WE=0; at the clock edge dataReg<=RD, go WRITE.
- WRITE: A={dstReg,2'b00}, WE=1, WD=dataReg; at the edge count<=count-1; srcReg+=1 unless srcFixed; dstReg+=1 unless dstFixed; go DONE if count==1, else READ.
- DONE: done=1 for exactly this cycle; go IDLE.
- `dmaIRQ` is set on the edge entering DONE and cleared by irqClear. If set and clear occur in the same cycle, set wins.
- Address arithmetic is word-granular, modulo 2^30 (wraps 0xFFFF_FFFC -> 0x0000_0000 silently).
- `wordsLeft` = count register; loads len on start, decrements after each WRITE, and reads 0 in IDLE after completion or abort.
- abort in READ or WRITE: WE forced 0 combinationally in that cycle, so no partial write occurs. Next state IDLE; no done, no IRQ, count cleared. abort in IDLE or DONE is ignored.
- start while busy is ignored; latched parameters do not change.
- Reset at any time: state IDLE, all registers 0, dmaIRQ=0, done=0. The bus is released immediately (asynchronously).

## Timing
- Reset values: busy=0, done=0, dmaIRQ=0, wordsLeft=0, A=0, WE=0, WD=0.
- Cycle 0 = the IDLE cycle with start=1. For len=N>0, cycles 1..2N alternate READ/WRITE, with the first READ in cycle 1. Cycle 2N+1 is DONE (done=1, dmaIRQ first visible). Cycle 2N+2 is IDLE.
- For len=0: cycle 1 is DONE and cycle 2 is IDLE; no bus activity.
- Throughput is 1 word per 2 cycles. A new start is accepted in cycle 2N+2 at the earliest.
- busy is high in cycles 1..2N+1.
- Read data is captured from RD at the end of the READ cycle; the bus must return data combinationally.

## Test plan
- Copy 3 words, src 0x1000 -> dst 0x2000, memory model holds 0xA, 0xB, 0xC -> writes at 0x2000/4/8 in cycles 2/4/6; done in cycle 7; dmaIRQ=1; wordsLeft steps 3,2,1,0.
- len=0 -> WE never asserted; done=1 in cycle 1; dmaIRQ set.
- srcFixed=1, src=0x2000_0000 (sysTimer mtime low), len=4, dst 0x3000 -> 4 reads of the same address; dst receives 4 strictly increasing timer values 2 apart.
- Abort asserted in the 2nd WRITE cycle of a len=5 transfer -> WE=0 in that cycle; only 1 word written; busy=0 next cycle; no done; dmaIRQ stays 0; wordsLeft=0.
- start pulsed mid-transfer with different addresses -> ignored; original transfer completes unchanged. irqClear and DONE in the same cycle -> dmaIRQ=1.
- Asynchronous reset asserted mid-WRITE -> A, WE, busy drop to 0 without a clock; after release the block is in IDLE and accepts a fresh len=1 transfer correctly.
